// File: rtl/sipo_deserializer.sv
// rtl/sipo_deserializer.sv - framed serial-to-parallel word collector with valid/ready output
//
// Collects a serial bit stream, framed by a start-of-frame marker on the first
// bit of every word, into WIDTH-bit words. Each finished word goes into a
// single-entry holding register that the consumer drains through a
// valid/ready handshake. Two sticky error flags report dropped words and
// frames that restart before they are complete.
//
// Parameters:
//   WIDTH      bits per word (>= 2)
//   MSB_FIRST  0: first received bit lands in bit 0; 1: first bit lands in bit WIDTH-1
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous, active-high reset
//   bit_in     serial data bit
//   bit_valid  bit_in is sampled on this cycle
//   sof        start-of-frame, qualified by bit_valid; marks bit 0 of a word
//   out_data   assembled word, stable while out_valid && !out_ready
//   out_valid  out_data holds an unconsumed word
//   out_ready  consumer takes the word when out_valid && out_ready
//   bit_count  bits collected in the current partial word
//   overrun    sticky: a completed word was dropped because the holding register was full
//   frame_err  sticky: sof arrived in the middle of a word
//   err_clr    clears overrun and frame_err (a same-cycle new error wins)

module sipo_deserializer #(
  parameter int WIDTH     = 8,
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   bit_in,
  input  logic                   bit_valid,
  input  logic                   sof,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(WIDTH):0] bit_count,
  output logic                   overrun,
  output logic                   frame_err,
  input  logic                   err_clr
);

  localparam int CW = $clog2(WIDTH) + 1;

  // A word needs at least two bits: the sof bit can never also be the last bit.
  if (WIDTH < 2) begin : g_width_check
    $error("sipo_deserializer: WIDTH must be >= 2");
  end

  typedef enum logic {
    HUNT  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;

  // Shift one bit into a word image in the configured direction. After WIDTH
  // shifts the first bit sits in bit 0 (LSB-first) or bit WIDTH-1 (MSB-first).
  function automatic logic [WIDTH-1:0] shift_in(input logic [WIDTH-1:0] base,
                                                input logic             b);
    if (MSB_FIRST) begin
      return {base[WIDTH-2:0], b};
    end else begin
      return {b, base[WIDTH-1:1]};
    end
  endfunction

  logic             start_bit;
  logic             data_bit;
  logic             last_bit;
  logic             slot_free;
  logic [WIDTH-1:0] shreg_next;
  logic [WIDTH-1:0] first_word;

  always_comb begin
    start_bit  = bit_valid && sof;
    data_bit   = bit_valid && !sof && (state == SHIFT);
    last_bit   = data_bit && (bit_count == CW'(WIDTH - 1));
    // The holding register can take a new word if it is empty or is being
    // drained on this very cycle.
    slot_free  = !out_valid || out_ready;
    shreg_next = shift_in(shreg, bit_in);
    // A sof bit always starts from an empty image so that a discarded partial
    // word leaves no residue behind.
    first_word = shift_in('0, bit_in);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= HUNT;
      shreg     <= '0;
      bit_count <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      // Bit collection
      if (start_bit) begin
        shreg     <= first_word;
        bit_count <= CW'(1);
        state     <= SHIFT;
      end else if (data_bit) begin
        shreg <= shreg_next;
        if (last_bit) begin
          bit_count <= '0;
          state     <= HUNT;
        end else begin
          bit_count <= bit_count + CW'(1);
        end
      end

      // Holding register and handshake
      if (last_bit && slot_free) begin
        out_data  <= shreg_next;
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end

      // Sticky flags: a new error on the clearing cycle takes priority.
      if (last_bit && !slot_free) begin
        overrun <= 1'b1;
      end else if (err_clr) begin
        overrun <= 1'b0;
      end

      if (start_bit && (state == SHIFT)) begin
        frame_err <= 1'b1;
      end else if (err_clr) begin
        frame_err <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sipo_deserializer.sv
// tb/tb_sipo_deserializer.sv - self-checking bench for sipo_deserializer (LSB-first and MSB-first)

module tb_sipo_deserializer;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst;
  logic bit_in;
  logic bit_valid;
  logic sof;
  logic out_ready;
  logic err_clr;

  logic [W-1:0] o_data  [2];
  logic         o_valid [2];
  logic [3:0]   o_count [2];
  logic         o_ov    [2];
  logic         o_fe    [2];

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .out_data(o_data[0]), .out_valid(o_valid[0]), .out_ready(out_ready),
    .bit_count(o_count[0]), .overrun(o_ov[0]), .frame_err(o_fe[0]), .err_clr(err_clr)
  );

  sipo_deserializer #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
    .clk(clk), .rst(rst), .bit_in(bit_in), .bit_valid(bit_valid), .sof(sof),
    .out_data(o_data[1]), .out_valid(o_valid[1]), .out_ready(out_ready),
    .bit_count(o_count[1]), .overrun(o_ov[1]), .frame_err(o_fe[1]), .err_clr(err_clr)
  );

  // Reference model: a word is a list of received bits placed by index;
  // index 0 is the sof bit. Model 0 is LSB-first, model 1 MSB-first.
  bit       m_in_frame [2];
  int       m_cnt      [2];
  bit [W-1:0] m_acc    [2];
  bit [W-1:0] m_data   [2];
  bit       m_valid    [2];
  bit       m_ov       [2];
  bit       m_fe       [2];

  function automatic int bit_pos(input int k, input int idx);
    return (k == 1) ? (W - 1 - idx) : idx;
  endfunction

  task automatic model_update(input logic bv, input logic b, input logic s,
                              input logic rdy, input logic clr, input logic r);
    for (int k = 0; k < 2; k++) begin
      bit complete;
      bit ov_set;
      bit fe_set;
      complete = 0;
      ov_set   = 0;
      fe_set   = 0;
      if (r) begin
        m_in_frame[k] = 0; m_cnt[k] = 0; m_acc[k] = '0;
        m_data[k] = '0; m_valid[k] = 0; m_ov[k] = 0; m_fe[k] = 0;
      end else begin
        if (bv && s) begin
          if (m_in_frame[k]) fe_set = 1;
          m_acc[k] = '0;
          m_acc[k][bit_pos(k, 0)] = b;
          m_cnt[k] = 1;
          m_in_frame[k] = 1;
        end else if (bv && m_in_frame[k]) begin
          m_acc[k][bit_pos(k, m_cnt[k])] = b;
          m_cnt[k]++;
          if (m_cnt[k] == W) begin
            complete = 1;
            m_cnt[k] = 0;
            m_in_frame[k] = 0;
          end
        end
        if (complete && (!m_valid[k] || rdy)) begin
          m_data[k]  = m_acc[k];
          m_valid[k] = 1;
        end else begin
          if (complete) ov_set = 1;
          if (m_valid[k] && rdy) m_valid[k] = 0;
        end
        if (ov_set) m_ov[k] = 1; else if (clr) m_ov[k] = 0;
        if (fe_set) m_fe[k] = 1; else if (clr) m_fe[k] = 0;
      end
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int k = 0; k < 2; k++) begin
      string sfx;
      sfx = (k == 0) ? "lsb" : "msb";
      chk({"out_data_", sfx},  32'(o_data[k]),  32'(m_data[k]));
      chk({"out_valid_", sfx}, 32'(o_valid[k]), 32'(m_valid[k]));
      chk({"bit_count_", sfx}, 32'(o_count[k]), 32'(m_cnt[k]));
      chk({"overrun_", sfx},   32'(o_ov[k]),    32'(m_ov[k]));
      chk({"frame_err_", sfx}, 32'(o_fe[k]),    32'(m_fe[k]));
    end
  endtask

  // Drive one cycle, advance the model at the edge, compare 1 time unit later.
  task automatic step(input logic bv, input logic b, input logic s,
                      input logic rdy, input logic clr, input logic r);
    bit_valid = bv; bit_in = b; sof = s; out_ready = rdy; err_clr = clr; rst = r;
    @(posedge clk);
    model_update(bv, b, s, rdy, clr, r);
    #1;
    check_all();
  endtask

  // Send n bits of v, v[0] first; sof on the first bit if first_sof.
  // out_ready is rdy for all bits except the last, which uses last_rdy.
  task automatic send_seq(input logic [W-1:0] v, input int n, input logic first_sof,
                          input logic rdy, input logic last_rdy);
    for (int i = 0; i < n; i++) begin
      step(1'b1, v[i], (i == 0) && first_sof, (i == n - 1) ? last_rdy : rdy, 1'b0, 1'b0);
    end
  endtask

  initial begin
    bit_valid = 0; bit_in = 0; sof = 0; out_ready = 0; err_clr = 0; rst = 1;
    for (int k = 0; k < 2; k++) begin
      m_in_frame[k] = 0; m_cnt[k] = 0; m_acc[k] = '0;
      m_data[k] = '0; m_valid[k] = 0; m_ov[k] = 0; m_fe[k] = 0;
    end

    // Reset state
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    chk("reset_valid", 32'(o_valid[0]), 32'd0);
    chk("reset_count", 32'(o_count[0]), 32'd0);

    // 0xA5 LSB-first, visible right after the edge that takes the 8th bit
    send_seq(8'hA5, 8, 1, 0, 0);
    chk("a5_valid", 32'(o_valid[0]), 32'd1);
    chk("a5_data",  32'(o_data[0]),  32'hA5);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);

    // Bit order: 1,0,...,0,1 and 1,1,0,...,0
    send_seq(8'h81, 8, 1, 1, 1);
    chk("x81_lsb", 32'(o_data[0]), 32'h81);
    chk("x81_msb", 32'(o_data[1]), 32'h81);
    step(0, 0, 0, 1, 0, 0);
    send_seq(8'h03, 8, 1, 1, 1);
    chk("x03_lsb", 32'(o_data[0]), 32'h03);
    chk("xc0_msb", 32'(o_data[1]), 32'hC0);
    step(0, 0, 0, 1, 0, 0);

    // Overrun with out_ready held low, then err_clr
    send_seq(8'h11, 8, 1, 0, 0);
    send_seq(8'h22, 8, 1, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("ovr_data", 32'(o_data[0]), 32'h11);
    chk("ovr_flag", 32'(o_ov[0]),   32'd1);
    step(0, 0, 0, 0, 1, 0);
    chk("ovr_clr",  32'(o_ov[0]),   32'd0);

    // Completion on the same cycle the held 0x11 is consumed
    send_seq(8'h33, 8, 1, 0, 1);
    chk("simul_valid", 32'(o_valid[0]), 32'd1);
    chk("simul_data",  32'(o_data[0]),  32'h33);
    chk("simul_ovr",   32'(o_ov[0]),    32'd0);
    step(0, 0, 0, 1, 0, 0);

    // Framing error: 3 bits, then a fresh sof frame of 0x5A
    send_seq(8'h07, 3, 1, 1, 1);
    send_seq(8'h5A, 8, 1, 1, 1);
    chk("fe_flag", 32'(o_fe[0]),   32'd1);
    chk("fe_data", 32'(o_data[0]), 32'h5A);
    step(0, 0, 0, 1, 0, 0);
    // Bits without sof in HUNT produce nothing
    send_seq(8'hFF, 8, 0, 1, 1);
    chk("hunt_novalid", 32'(o_valid[0]), 32'd0);
    chk("hunt_count",   32'(o_count[0]), 32'd0);
    // err_clr colliding with a new framing error: set wins
    send_seq(8'h01, 2, 1, 1, 1);
    step(1, 1, 1, 1, 1, 0);
    chk("fe_set_wins", 32'(o_fe[0]), 32'd1);
    step(0, 0, 0, 1, 1, 0);
    chk("fe_cleared",  32'(o_fe[0]), 32'd0);

    // Reset mid-word with a held word and a sticky flag
    send_seq(8'h77, 8, 1, 0, 0);
    send_seq(8'h1F, 5, 1, 0, 0);
    step(1, 0, 1, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    chk("rst_valid", 32'(o_valid[0]), 32'd0);
    chk("rst_count", 32'(o_count[0]), 32'd0);
    chk("rst_fe",    32'(o_fe[0]),    32'd0);
    send_seq(8'h3C, 8, 1, 0, 0);
    chk("post_rst_data", 32'(o_data[0]), 32'h3C);
    step(0, 0, 0, 1, 0, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      step(($urandom % 4) != 0, $urandom % 2, ($urandom % 9) == 0,
           ($urandom % 3) != 0, ($urandom % 40) == 0, ($urandom % 700) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
